cpu_execute: RTL and testbench

- Execute/writeback stage of the 4-bit CPU, directly downstream of the instruction decoder.
- Consumes the decoded OPECODE and 4-bit immediate, and owns the architectural state: registers A and B, carry flag, output port and program counter.
- Drives the PC back to fetch/decode and retires at most one instruction per enabled cycle.
- Halts on an INVALID opcode.

---
 rtl/lib_cpu.sv | 30 +++
 rtl/cpu_tick_gen.sv | 30 +++
 rtl/cpu_execute.sv | 133 +++++++++++++
 tb/tb_cpu_execute.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lib_cpu.sv
// Shared types for the 4-bit CPU: decoded opcodes, execute-stage FSM states, datapath width.
// Latency: none; declarations only.
// Backpressure: not applicable.
package lib_cpu;

   localparam int DATA_W = 4;

   // Decoded operation handed from the decoder to the execute stage
   typedef enum logic [3:0] {
      MOV_A_B   = 4'd0,
      MOV_B_A   = 4'd1,
      MOV_A_IMM = 4'd2,
      MOV_B_IMM = 4'd3,
      IN_A      = 4'd4,
      IN_B      = 4'd5,
      OUT_B     = 4'd6,
      OUT_IMM   = 4'd7,
      ADD_A_IMM = 4'd8,
      ADD_B_IMM = 4'd9,
      JMP_IMM   = 4'd10,
      JNC_IMM   = 4'd11,
      INVALID   = 4'd15
   } OPECODE;

   typedef enum logic {
      EXEC_RUN  = 1'b0,
      EXEC_HALT = 1'b1
   } EXEC_STATE;

endpackage

// File: rtl/cpu_tick_gen.sv
// Retire-tick divider: tick is high once every CLK_DIV enabled cycles.
// Latency: tick is combinational from the registered count; the count advances one step per enabled cycle.
// Backpressure: en low freezes the count (used to hold the divider while the core is halted).
module cpu_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   // CLK_DIV = 1 still needs one bit; that bit simply stays 0 and tick is permanently high.
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-CLK_DIV counter, paused when en is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/cpu_execute.sv
// Execute/writeback stage of the 4-bit CPU: owns A, B, carry, out_port and PC; halts on INVALID.
// Latency: one cycle; results and the retire pulse appear the cycle after the executing edge.
// Backpressure: none upstream; instr_valid is consumed only in RUN on tick cycles (CPU_CLK_DIV_EN enables the divider).
module cpu_execute
   import lib_cpu::*;
#(
   parameter int PC_W    = 4,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  OPECODE            opecode,
   input  logic [DATA_W-1:0] imm,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] in_port,
   output logic [31:0]       pc,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic [DATA_W-1:0] out_port,
   output logic              carry,
   output logic              retire,
   output logic              halted
);

   // A zero divisor has no meaningful tick; reject it when the design is elaborated.
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("cpu_execute: CLK_DIV must be >= 1");
   end

   EXEC_STATE         state_q, state_n;
   logic [PC_W-1:0]   pc_q, pc_n;
   logic [DATA_W-1:0] a_q, a_n;
   logic [DATA_W-1:0] b_q, b_n;
   logic [DATA_W-1:0] out_q, out_n;
   logic              carry_q, carry_n;
   logic              retire_q, retire_n;
   logic              tick;
   logic              exec;
   logic [PC_W-1:0]   pc_inc;
   logic [DATA_W:0]   sum_a;
   logic [DATA_W:0]   sum_b;

`ifdef CPU_CLK_DIV_EN
   // The divider only advances while running so a halted core stays frozen.
   cpu_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q == EXEC_RUN),
      .tick  (tick)
   );
`else
   assign tick = 1'b1;
`endif

   assign exec   = (state_q == EXEC_RUN) && instr_valid && tick;
   assign pc_inc = pc_q + PC_W'(1);
   assign sum_a  = {1'b0, a_q} + {1'b0, imm};
   assign sum_b  = {1'b0, b_q} + {1'b0, imm};

   // Next architectural state for the single instruction that may retire this cycle
   always_comb begin
      state_n  = state_q;
      pc_n     = pc_q;
      a_n      = a_q;
      b_n      = b_q;
      out_n    = out_q;
      carry_n  = carry_q;
      retire_n = 1'b0;
      if (exec) begin
         if (opecode == INVALID) begin
            // Unknown or INVALID encodings stop the core without touching any register.
            state_n = EXEC_HALT;
         end else begin
            retire_n = 1'b1;
            pc_n     = pc_inc;
            carry_n  = 1'b0;
            case (opecode)
               MOV_A_B:   a_n   = b_q;
               MOV_B_A:   b_n   = a_q;
               MOV_A_IMM: a_n   = imm;
               MOV_B_IMM: b_n   = imm;
               IN_A:      a_n   = in_port;
               IN_B:      b_n   = in_port;
               OUT_B:     out_n = b_q;
               OUT_IMM:   out_n = imm;
               ADD_A_IMM: {carry_n, a_n} = sum_a;
               ADD_B_IMM: {carry_n, b_n} = sum_b;
               JMP_IMM:   pc_n  = PC_W'(imm);
               // Carry tested here is the value before this instruction; it is cleared above.
               JNC_IMM:   pc_n  = carry_q ? pc_inc : PC_W'(imm);
               default: begin
                  state_n  = EXEC_HALT;
                  retire_n = 1'b0;
                  pc_n     = pc_q;
                  carry_n  = carry_q;
               end
            endcase
         end
      end
   end

   // Architectural state registers; reset overrides halt and any pending tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= EXEC_RUN;
         pc_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         out_q    <= '0;
         carry_q  <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         pc_q     <= pc_n;
         a_q      <= a_n;
         b_q      <= b_n;
         out_q    <= out_n;
         carry_q  <= carry_n;
         retire_q <= retire_n;
      end
   end

   assign pc       = 32'(pc_q);
   assign reg_a    = a_q;
   assign reg_b    = b_q;
   assign out_port = out_q;
   assign carry    = carry_q;
   assign retire   = retire_q;
   assign halted   = (state_q == EXEC_HALT);

endmodule

// File: tb/tb_cpu_execute.sv
// Directed bench for cpu_execute with a cycle-level reference model and literal checkpoints.
// Latency: model results are compared on the falling edge after each rising edge.
// Backpressure: not applicable; the bench drives instr_valid directly.
module tb_cpu_execute;
   import lib_cpu::*;

   localparam int PC_W = 4;
`ifdef CPU_CLK_DIV_EN
   localparam int DIV = 3;
`else
   localparam int DIV = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   OPECODE      opecode;
   logic [3:0]  imm;
   logic        instr_valid;
   logic [3:0]  in_port;
   logic [31:0] pc;
   logic [3:0]  reg_a, reg_b, out_port;
   logic        carry, retire, halted;

   int total = 0;
   int bad   = 0;

   cpu_execute #(.PC_W(PC_W), .CLK_DIV(DIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opecode     (opecode),
      .imm         (imm),
      .instr_valid (instr_valid),
      .in_port     (in_port),
      .pc          (pc),
      .reg_a       (reg_a),
      .reg_b       (reg_b),
      .out_port    (out_port),
      .carry       (carry),
      .retire      (retire),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state as plain integers
   int m_a, m_b, m_out, m_c, m_pc, m_ret, m_halt, m_run;
   bit m_valid = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_pc = 0;
         m_ret = 0; m_halt = 0; m_run = 0; m_valid = 1;
      end else if (m_valid) begin
         int s;
         bit tk;
         tk = ((m_run % DIV) == DIV - 1);
         if (m_halt == 0) m_run++;
         m_ret = 0;
         if (m_halt == 0 && instr_valid && tk) begin
            if (opecode == INVALID) begin
               m_halt = 1;
            end else begin
               int next_pc;
               int old_c;
               old_c   = m_c;
               next_pc = (m_pc + 1) % (1 << PC_W);
               m_c     = 0;
               case (opecode)
                  MOV_A_B:   m_a = m_b;
                  MOV_B_A:   m_b = m_a;
                  MOV_A_IMM: m_a = imm;
                  MOV_B_IMM: m_b = imm;
                  IN_A:      m_a = in_port;
                  IN_B:      m_b = in_port;
                  OUT_B:     m_out = m_b;
                  OUT_IMM:   m_out = imm;
                  ADD_A_IMM: begin s = m_a + imm; m_a = s % 16; m_c = (s >= 16); end
                  ADD_B_IMM: begin s = m_b + imm; m_b = s % 16; m_c = (s >= 16); end
                  JMP_IMM:   next_pc = imm % (1 << PC_W);
                  JNC_IMM:   if (old_c == 0) next_pc = imm % (1 << PC_W);
                  default:   ;
               endcase
               m_pc  = next_pc;
               m_ret = 1;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (m_valid) begin
         check("pc", pc, 32'(m_pc));
         check("reg_a", 32'(reg_a), 32'(m_a));
         check("reg_b", 32'(reg_b), 32'(m_b));
         check("out_port", 32'(out_port), 32'(m_out));
         check("carry", 32'(carry), 32'(m_c));
         check("retire", 32'(retire), 32'(m_ret));
         check("halted", 32'(halted), 32'(m_halt));
      end
   end

   task automatic step(input logic r, input OPECODE o, input logic [3:0] i,
                       input logic v, input logic [3:0] p);
      rst_n = r; opecode = o; imm = i; instr_valid = v; in_port = p;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; opecode = ADD_A_IMM; imm = 4'h5; instr_valid = 1'b1; in_port = 4'h0;
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'd0);
      check("rst_a", 32'(reg_a), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);

`ifdef CPU_CLK_DIV_EN
      begin
         int n;
         n = 0;
         rst_n = 1'b1; opecode = MOV_A_IMM; imm = 4'h4; instr_valid = 1'b1;
         for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (retire) n++;
            check("div_retire", 32'(retire), (k % 3 == 2) ? 32'd1 : 32'd0);
         end
         check("div_count", 32'(n), 32'd3);
         check("div_pc", pc, 32'd3);
      end
`else
      step(1, MOV_A_IMM, 4'h3, 1, 4'h0);
      check("first_a", 32'(reg_a), 32'd3);
      check("first_pc", pc, 32'd1);
      check("first_retire", 32'(retire), 32'd1);

      step(1, MOV_A_IMM, 4'h5, 1, 4'h0);
      step(1, ADD_A_IMM, 4'hC, 1, 4'h0);
      check("add_a", 32'(reg_a), 32'd1);
      check("add_carry", 32'(carry), 32'd1);
      step(1, JNC_IMM, 4'h7, 1, 4'h0);
      check("jnc_taken_no_pc", pc, 32'd4);
      check("jnc_clear_c", 32'(carry), 32'd0);
      step(1, JNC_IMM, 4'h7, 1, 4'h0);
      check("jnc_pc", pc, 32'd7);

      step(1, IN_B, 4'h0, 1, 4'hA);
      check("in_b", 32'(reg_b), 32'hA);
      step(1, OUT_B, 4'h0, 1, 4'h0);
      check("out_b", 32'(out_port), 32'hA);
      step(1, MOV_A_B, 4'h0, 1, 4'h0);
      check("mov_a_b", 32'(reg_a), 32'hA);
      step(1, OUT_IMM, 4'h3, 1, 4'h0);
      check("out_imm", 32'(out_port), 32'd3);
      check("pc_11", pc, 32'd11);
      step(1, ADD_B_IMM, 4'h7, 1, 4'h0);
      check("add_b", 32'(reg_b), 32'd1);
      check("add_b_c", 32'(carry), 32'd1);
      step(1, MOV_B_A, 4'h0, 1, 4'h0);
      check("mov_b_a", 32'(reg_b), 32'hA);
      check("mov_clr_c", 32'(carry), 32'd0);

      step(1, JMP_IMM, 4'hF, 1, 4'h0);
      check("jmp_pc", pc, 32'd15);
      step(1, MOV_B_IMM, 4'h1, 1, 4'h0);
      check("wrap_pc", pc, 32'd0);
      for (int k = 0; k < 5; k++) step(1, ADD_A_IMM, 4'h1, 0, 4'h0);
      check("idle_pc", pc, 32'd0);
      check("idle_b", 32'(reg_b), 32'd1);
      check("idle_retire", 32'(retire), 32'd0);

      step(1, IN_A, 4'h0, 1, 4'h6);
      check("in_a", 32'(reg_a), 32'd6);
      step(1, MOV_A_IMM, 4'h9, 1, 4'h0);
      step(1, INVALID, 4'h0, 1, 4'h0);
      check("halt", 32'(halted), 32'd1);
      check("halt_pc", pc, 32'd2);
      check("halt_retire", 32'(retire), 32'd0);
      for (int k = 0; k < 3; k++) step(1, ADD_A_IMM, 4'h1, 1, 4'h0);
      check("halt_a", 32'(reg_a), 32'd9);
      check("halt_hold", 32'(halted), 32'd1);
      step(0, ADD_A_IMM, 4'h1, 1, 4'h0);
      check("unhalt", 32'(halted), 32'd0);
      check("unhalt_pc", pc, 32'd0);
      step(1, MOV_B_IMM, 4'h4, 1, 4'h0);
      step(1, MOV_A_B, 4'h0, 1, 4'h0);
      check("post_a", 32'(reg_a), 32'd4);
      check("post_pc", pc, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
